// File: rtl/nnrv_mem_arb.sv
// Single-port RAM front-end that arbitrates instruction-fetch and data-memory requesters,
// with configurable read latency, byte-lane writes and out-of-range detection.
module nnrv_mem_arb #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned MAX_DM_RUN = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_if_req,
   input  logic [XLEN-1:0]       i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [XLEN-1:0]       o_if_rdata,
   output logic                  o_if_err,
   input  logic                  i_dm_req,
   input  logic                  i_dm_we,
   input  logic [XLEN-1:0]       i_dm_addr,
   input  logic [XLEN/8-1:0]     i_dm_mask,
   input  logic [XLEN-1:0]       i_dm_wdata,
   output logic                  o_dm_gnt,
   output logic                  o_dm_rvalid,
   output logic [XLEN-1:0]       o_dm_rdata,
   output logic                  o_dm_err,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [XLEN/8-1:0]     o_ram_mask,
   output logic [XLEN-1:0]       o_ram_wdata,
   input  logic [XLEN-1:0]       i_ram_rdata
);

   localparam int unsigned MW = XLEN / 8;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                state_q, state_d;
   logic [3:0]            dm_run_q, dm_run_d;
   logic [2:0]            wait_q, wait_d;
   logic                  port_dm_q, port_dm_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [MW-1:0]         ram_mask_q, ram_mask_d;
   logic [XLEN-1:0]       ram_wdata_q, ram_wdata_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  if_err_q, if_err_d;
   logic [XLEN-1:0]       if_rdata_q, if_rdata_d;
   logic                  dm_rvalid_q, dm_rvalid_d;
   logic                  dm_err_q, dm_err_d;
   logic [XLEN-1:0]       dm_rdata_q, dm_rdata_d;

   logic            arb_ok, run_full, if_gnt, dm_gnt, sel_oor;
   logic [XLEN-1:0] sel_addr;

   // RESP behaves like IDLE so a new access can be granted in the rvalid cycle.
   assign arb_ok   = i_rst && (state_q == StIdle || state_q == StResp);
   assign run_full = (dm_run_q == 4'(MAX_DM_RUN));
   assign if_gnt   = arb_ok && i_if_req && (!i_dm_req || run_full);
   assign dm_gnt   = arb_ok && i_dm_req && !if_gnt;
   assign sel_addr = dm_gnt ? i_dm_addr : i_if_addr;
   assign sel_oor  = |sel_addr[XLEN-1:ADDR_WIDTH+2];

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      port_dm_d   = port_dm_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_mask_d  = '0;
      ram_wdata_d = '0;
      if_rvalid_d = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rvalid_d = 1'b0;
      dm_err_d    = 1'b0;
      dm_rdata_d  = dm_rdata_q;

      if (!i_if_req || if_gnt) begin
         dm_run_d = '0;
      end else if (dm_gnt && !run_full) begin
         dm_run_d = dm_run_q + 4'd1;
      end else begin
         dm_run_d = dm_run_q;
      end

      case (state_q)
         StIssue: begin
            wait_d = '0;
            if (ram_we_q) begin
               state_d     = StResp;
               dm_rvalid_d = 1'b1;
               dm_rdata_d  = '0;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (wait_q == 3'(RD_LATENCY - 1)) begin
               state_d = StResp;
               if (port_dm_q) begin
                  dm_rvalid_d = 1'b1;
                  dm_rdata_d  = i_ram_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = i_ram_rdata;
               end
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end
         default: begin
            state_d = StIdle;
            if (if_gnt || dm_gnt) begin
               port_dm_d = dm_gnt;
               if (sel_oor) begin
                  // Out-of-range: answer with an error without touching the RAM.
                  state_d = StResp;
                  if (dm_gnt) begin
                     dm_rvalid_d = 1'b1;
                     dm_err_d    = 1'b1;
                     dm_rdata_d  = '0;
                  end else begin
                     if_rvalid_d = 1'b1;
                     if_err_d    = 1'b1;
                     if_rdata_d  = '0;
                  end
               end else begin
                  state_d     = StIssue;
                  ram_en_d    = 1'b1;
                  ram_we_d    = dm_gnt && i_dm_we;
                  ram_addr_d  = sel_addr[ADDR_WIDTH+1:2];
                  ram_mask_d  = ram_we_d ? i_dm_mask : '1;
                  ram_wdata_d = ram_we_d ? i_dm_wdata : '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= StIdle;
         dm_run_q    <= '0;
         wait_q      <= '0;
         port_dm_q   <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_mask_q  <= '0;
         ram_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rvalid_q <= 1'b0;
         dm_err_q    <= 1'b0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         dm_run_q    <= dm_run_d;
         wait_q      <= wait_d;
         port_dm_q   <= port_dm_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_mask_q  <= ram_mask_d;
         ram_wdata_q <= ram_wdata_d;
         if_rvalid_q <= if_rvalid_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         dm_rvalid_q <= dm_rvalid_d;
         dm_err_q    <= dm_err_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign o_if_gnt    = if_gnt;
   assign o_dm_gnt    = dm_gnt;
   assign o_if_rvalid = if_rvalid_q;
   assign o_if_err    = if_err_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_dm_rvalid = dm_rvalid_q;
   assign o_dm_err    = dm_err_q;
   assign o_dm_rdata  = dm_rdata_q;
   assign o_ram_en    = ram_en_q;
   assign o_ram_we    = ram_we_q;
   assign o_ram_addr  = ram_addr_q;
   assign o_ram_mask  = ram_mask_q;
   assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Directed bench for nnrv_mem_arb: one instance with RD_LATENCY=1, one with RD_LATENCY=3,
// each backed by a behavioural RAM model of matching latency.
module tb_nnrv_mem_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel3 = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [3:0]  dm_mask = '0;
   logic [31:0] dm_wdata = '0;
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   logic        if_gnt_1, if_rvalid_1, if_err_1, dm_gnt_1, dm_rvalid_1, dm_err_1;
   logic        ram_en_1, ram_we_1;
   logic [31:0] if_rdata_1, dm_rdata_1, ram_wdata_1, rd1;
   logic [7:0]  ram_addr_1;
   logic [3:0]  ram_mask_1;
   logic        if_gnt_3, if_rvalid_3, if_err_3, dm_gnt_3, dm_rvalid_3, dm_err_3;
   logic        ram_en_3, ram_we_3;
   logic [31:0] if_rdata_3, dm_rdata_3, ram_wdata_3, p0, p1, p2;
   logic [7:0]  ram_addr_3;
   logic [3:0]  ram_mask_3;

   nnrv_mem_arb #(.XLEN(32), .ADDR_WIDTH(8), .RD_LATENCY(1), .MAX_DM_RUN(4)) u_dut1 (
      .i_clk(clk), .i_rst(rst_n),
      .i_if_req(if_req && !sel3), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt_1), .o_if_rvalid(if_rvalid_1), .o_if_rdata(if_rdata_1),
      .o_if_err(if_err_1),
      .i_dm_req(dm_req && !sel3), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_mask(dm_mask),
      .i_dm_wdata(dm_wdata),
      .o_dm_gnt(dm_gnt_1), .o_dm_rvalid(dm_rvalid_1), .o_dm_rdata(dm_rdata_1),
      .o_dm_err(dm_err_1),
      .o_ram_en(ram_en_1), .o_ram_we(ram_we_1), .o_ram_addr(ram_addr_1),
      .o_ram_mask(ram_mask_1), .o_ram_wdata(ram_wdata_1), .i_ram_rdata(rd1)
   );

   nnrv_mem_arb #(.XLEN(32), .ADDR_WIDTH(8), .RD_LATENCY(3), .MAX_DM_RUN(4)) u_dut3 (
      .i_clk(clk), .i_rst(rst_n),
      .i_if_req(if_req && sel3), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt_3), .o_if_rvalid(if_rvalid_3), .o_if_rdata(if_rdata_3),
      .o_if_err(if_err_3),
      .i_dm_req(dm_req && sel3), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_mask(dm_mask),
      .i_dm_wdata(dm_wdata),
      .o_dm_gnt(dm_gnt_3), .o_dm_rvalid(dm_rvalid_3), .o_dm_rdata(dm_rdata_3),
      .o_dm_err(dm_err_3),
      .o_ram_en(ram_en_3), .o_ram_we(ram_we_3), .o_ram_addr(ram_addr_3),
      .o_ram_mask(ram_mask_3), .o_ram_wdata(ram_wdata_3), .i_ram_rdata(p2)
   );

   // Behavioural RAMs: one-cycle and three-cycle read latency.
   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];

   always @(posedge clk) begin
      if (pre_we) begin
         mem1[pre_addr] <= pre_data;
      end else if (ram_en_1 && ram_we_1) begin
         for (int b = 0; b < 4; b++)
            if (ram_mask_1[b]) mem1[ram_addr_1][8*b +: 8] <= ram_wdata_1[8*b +: 8];
      end
      if (ram_en_1 && !ram_we_1) rd1 <= mem1[ram_addr_1];
   end

   always @(posedge clk) begin
      if (pre_we) begin
         mem3[pre_addr] <= pre_data;
      end else if (ram_en_3 && ram_we_3) begin
         for (int b = 0; b < 4; b++)
            if (ram_mask_3[b]) mem3[ram_addr_3][8*b +: 8] <= ram_wdata_3[8*b +: 8];
      end
      p0 <= (ram_en_3 && !ram_we_3) ? mem3[ram_addr_3] : 32'h0;
      p1 <= p0;
      p2 <= p1;
   end

   wire        if_gnt    = sel3 ? if_gnt_3    : if_gnt_1;
   wire        if_rvalid = sel3 ? if_rvalid_3 : if_rvalid_1;
   wire        if_err    = sel3 ? if_err_3    : if_err_1;
   wire [31:0] if_rdata  = sel3 ? if_rdata_3  : if_rdata_1;
   wire        dm_gnt    = sel3 ? dm_gnt_3    : dm_gnt_1;
   wire        dm_rvalid = sel3 ? dm_rvalid_3 : dm_rvalid_1;
   wire        dm_err    = sel3 ? dm_err_3    : dm_err_1;
   wire [31:0] dm_rdata  = sel3 ? dm_rdata_3  : dm_rdata_1;
   wire        ram_en    = sel3 ? ram_en_3    : ram_en_1;
   wire        ram_we    = sel3 ? ram_we_3    : ram_we_1;
   wire [7:0]  ram_addr  = sel3 ? ram_addr_3  : ram_addr_1;
   wire [3:0]  ram_mask  = sel3 ? ram_mask_3  : ram_mask_1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   // Entered and left at posedge+1. Latency counts cycles from the grant cycle to rvalid.
   task automatic access(input string tag, input bit dm, input bit we, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata, input int exp_lat,
                         input logic [31:0] exp_rdata, input bit exp_err, input bit exp_en);
      int w;
      int lat;
      logic [31:0] exp_waddr;
      exp_waddr = {24'h0, addr[9:2]};
      if (dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_mask = mask; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      w = 0;
      while (!(dm ? dm_gnt : if_gnt) && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, " gnt"}, {31'h0, dm ? dm_gnt : if_gnt}, 32'h1);
      @(posedge clk);
      #1;
      dm_req = 1'b0;
      if_req = 1'b0;
      @(negedge clk);
      check({tag, " ram_en"}, {31'h0, ram_en}, {31'h0, exp_en});
      if (exp_en) begin
         check({tag, " ram_addr"}, {24'h0, ram_addr}, exp_waddr);
         check({tag, " ram_we"}, {31'h0, ram_we}, {31'h0, we});
         check({tag, " ram_mask"}, {28'h0, ram_mask}, {28'h0, we ? mask : 4'hF});
      end
      lat = 1;
      while (!(dm ? dm_rvalid : if_rvalid) && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, dm ? dm_rdata : if_rdata, exp_rdata);
      check({tag, " err"}, {31'h0, dm ? dm_err : if_err}, {31'h0, exp_err});
      @(posedge clk);
      #1;
   endtask

   initial begin
      string  exp_ord;
      byte    order [10];
      int     gcyc [10];
      int     ng;
      int     cyc;
      bit     rv_seen;

      // Reset: outputs must stay low even with a request pending.
      if_req  = 1'b1;
      if_addr = 32'h10;
      repeat (2) @(negedge clk);
      check("rst if_gnt", {31'h0, if_gnt_1}, 32'h0);
      check("rst ram_en", {31'h0, ram_en_1}, 32'h0);
      check("rst if_rvalid", {31'h0, if_rvalid_1}, 32'h0);
      check("rst dm_rdata", dm_rdata_1, 32'h0);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      rst_n  = 1'b1;

      preload(8'd4, 32'hDEADBEEF);
      preload(8'd2, 32'hAABBCCDD);
      preload(8'd3, 32'h12345678);

      access("if rd 0x10", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b1);
      access("dm wr 0x08", 1'b1, 1'b1, 32'h08, 4'b0011, 32'h11223344, 2, 32'h0, 1'b0, 1'b1);
      check("if_rdata hold", if_rdata_1, 32'hDEADBEEF);
      access("dm rd 0x08", 1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 3, 32'hAABB3344, 1'b0, 1'b1);
      access("dm wr mask0", 1'b1, 1'b1, 32'h0C, 4'b0000, 32'hFFFFFFFF, 2, 32'h0, 1'b0, 1'b1);
      access("dm rd 0x0c", 1'b1, 1'b0, 32'h0C, 4'h0, 32'h0, 3, 32'h12345678, 1'b0, 1'b1);
      access("if rd 0x13", 1'b0, 1'b0, 32'h13, 4'h0, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b1);
      access("dm oor 0x400", 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1, 32'h0, 1'b1, 1'b0);
      access("if oor", 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 1, 32'h0, 1'b1, 1'b0);
      access("dm rd 0x3fc", 1'b1, 1'b0, 32'h3FC, 4'h0, 32'h0, 3, mem1[255], 1'b0, 1'b1);

      // Both requesters held: DM runs at most four grants before IF gets one.
      if_req  = 1'b1; if_addr = 32'h10;
      dm_req  = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
      ng  = 0;
      cyc = 0;
      while (ng < 10 && cyc < 100) begin
         @(negedge clk);
         if (dm_gnt_1 || if_gnt_1) begin
            order[ng] = dm_gnt_1 ? 8'h44 : 8'h49;
            gcyc[ng]  = cyc;
            ng++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      check("arb grant count", 32'(ng), 32'd10);
      exp_ord = "DDDDIDDDDI";
      for (int i = 0; i < 10; i++) check($sformatf("arb order %0d", i), 32'(order[i]),
                                         32'(exp_ord[i]));
      check("arb gap DD", 32'(gcyc[1] - gcyc[0]), 32'd3);
      check("arb gap DI", 32'(gcyc[4] - gcyc[3]), 32'd3);
      repeat (6) @(posedge clk);
      #1;

      // Three-cycle-latency instance.
      sel3 = 1'b1;
      access("l3 if rd", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 1'b1);
      if_req  = 1'b1;
      if_addr = 32'h08;
      ng  = 0;
      cyc = 0;
      while (ng < 3 && cyc < 40) begin
         @(negedge clk);
         if (if_gnt_3) begin
            gcyc[ng] = cyc;
            ng++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if_req = 1'b0;
      check("l3 b2b count", 32'(ng), 32'd3);
      check("l3 b2b gap0", 32'(gcyc[1] - gcyc[0]), 32'd5);
      check("l3 b2b gap1", 32'(gcyc[2] - gcyc[1]), 32'd5);
      repeat (8) @(posedge clk);
      #1;

      // Reset while the read sits in WAIT: everything drops at once, no late rvalid.
      access("l3 pre-rst rd", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 1'b1);
      if_req  = 1'b1;
      if_addr = 32'h10;
      @(posedge clk);
      #1;
      if_req = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort if_rdata", if_rdata_3, 32'h0);
      check("abort ram_en", {31'h0, ram_en_3}, 32'h0);
      rv_seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         rv_seen = rv_seen | if_rvalid_3;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         rv_seen = rv_seen | if_rvalid_3;
      end
      check("abort no rvalid", {31'h0, rv_seen}, 32'h0);
      @(posedge clk);
      #1;
      access("l3 post-rst rd", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
